gdma_engine: RTL

- Parametrised block-copy engine; generalises the single-byte "LD (HL±),A" write-with-pointer-step into repeated read→write transfers.
- Independent source and destination pointers, each with its own step mode (increment, decrement or hold).
- Transfer length and address width are parametrised.
- Sits beside the CPU bus master and drives the same M-cycle/T-cycle bus protocol: one M-cycle = T_PER_M clocks, address valid from T1.

---
 rtl/gdma_pkg.sv | 33 +++
 rtl/gdma_ptr_step.sv | 33 +++
 rtl/gdma_engine.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/gdma_pkg.sv
// Shared types and pointer-step helpers for the block-copy engine.
package gdma_pkg;

  typedef enum logic [1:0] {
    STEP_INC  = 2'b00,
    STEP_DEC  = 2'b01,
    STEP_HOLD = 2'b10,
    STEP_RSVD = 2'b11
  } step_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10
  } state_t;

  // Widest pointer the step helper supports; callers truncate to their width.
  localparam int PTR_MAX_W = 64;

  function automatic step_mode_t decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? STEP_HOLD : step_mode_t'(m);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] step_ptr(input logic [PTR_MAX_W-1:0] p,
                                                    input step_mode_t m);
    case (m)
      STEP_INC: return p + PTR_MAX_W'(1);
      STEP_DEC: return p - PTR_MAX_W'(1);
      default:  return p;
    endcase
  endfunction

endpackage

// File: rtl/gdma_ptr_step.sv
// Pointer register with load and mode-controlled step; wraps modulo 2^ADR_W.
module gdma_ptr_step
  import gdma_pkg::*;
#(
  parameter int ADR_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_load,
  input  logic [ADR_W-1:0] i_load_val,
  input  logic             i_step,
  input  logic [1:0]       i_mode,
  output logic [ADR_W-1:0] o_ptr
);

  logic [ADR_W-1:0] r_ptr;
  logic [ADR_W-1:0] w_next;

  assign w_next = ADR_W'(step_ptr(PTR_MAX_W'(r_ptr), step_mode_t'(i_mode)));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_step) begin
      r_ptr <= w_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/gdma_engine.sv
// Block-copy engine: repeated read M-cycle from src, write M-cycle to dst,
// on the CPU-style T-cycle bus; abort honoured at M-cycle boundaries.
module gdma_engine
  import gdma_pkg::*;
#(
  parameter int ADR_W   = 16,
  parameter int LEN_W   = 8,
  parameter int T_PER_M = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADR_W-1:0] src,
  input  logic [ADR_W-1:0] dst,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       src_mode,
  input  logic [1:0]       dst_mode,
  output logic [ADR_W-1:0] adr,
  output logic             rd,
  output logic             wr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [ADR_W-1:0] cur_src,
  output logic [ADR_W-1:0] cur_dst,
  output logic [LEN_W:0]   remaining
);

  localparam int            TW     = $clog2(T_PER_M);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

  state_t           r_state;
  logic [TW-1:0]    r_tcnt;
  logic [ADR_W-1:0] r_adr;
  logic             r_rd;
  logic             r_wr;
  logic [7:0]       r_dout;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic [LEN_W:0]   r_remaining;
  logic             r_abort_pend;
  step_mode_t       r_src_mode;
  step_mode_t       r_dst_mode;

  logic w_last;
  logic w_abort;
  logic w_load;
  logic w_step;

  assign w_last  = (r_tcnt == T_LAST);
  assign w_abort = abort | r_abort_pend;
  assign w_load  = (r_state == ST_IDLE) && start;
  assign w_step  = (r_state == ST_WR) && w_last;

  gdma_ptr_step #(.ADR_W(ADR_W)) u_src_ptr (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (w_load),
    .i_load_val (src),
    .i_step     (w_step),
    .i_mode     (r_src_mode),
    .o_ptr      (cur_src)
  );

  gdma_ptr_step #(.ADR_W(ADR_W)) u_dst_ptr (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (w_load),
    .i_load_val (dst),
    .i_step     (w_step),
    .i_mode     (r_dst_mode),
    .o_ptr      (cur_dst)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= ST_IDLE;
      r_tcnt       <= '0;
      r_adr        <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_remaining  <= '0;
      r_abort_pend <= 1'b0;
      r_src_mode   <= STEP_INC;
      r_dst_mode   <= STEP_INC;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          if (start) begin
            r_state      <= ST_RD;
            r_busy       <= 1'b1;
            r_rd         <= 1'b1;
            r_adr        <= src;
            r_remaining  <= {1'b0, len} + (LEN_W+1)'(1);
            r_src_mode   <= decode_mode(src_mode);
            r_dst_mode   <= decode_mode(dst_mode);
            r_abort_pend <= 1'b0;
          end
        end
        ST_RD: begin
          if (!w_last) begin
            r_tcnt <= r_tcnt + TW'(1);
            if (abort) r_abort_pend <= 1'b1;
          end else begin
            r_tcnt <= '0;
            r_rd   <= 1'b0;
            if (w_abort) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_aborted    <= 1'b1;
              r_abort_pend <= 1'b0;
            end else begin
              r_state <= ST_WR;
              r_adr   <= cur_dst;
              r_dout  <= din;
            end
          end
        end
        ST_WR: begin
          if (!w_last) begin
            r_tcnt <= r_tcnt + TW'(1);
            r_wr   <= 1'b1;
            if (abort) r_abort_pend <= 1'b1;
          end else begin
            r_tcnt      <= '0;
            r_wr        <= 1'b0;
            r_remaining <= r_remaining - (LEN_W+1)'(1);
            // Completion takes priority over a coincident abort.
            if (r_remaining == (LEN_W+1)'(1)) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_abort_pend <= 1'b0;
            end else if (w_abort) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_aborted    <= 1'b1;
              r_abort_pend <= 1'b0;
            end else begin
              r_state <= ST_RD;
              r_rd    <= 1'b1;
              r_adr   <= ADR_W'(step_ptr(PTR_MAX_W'(cur_src), r_src_mode));
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tcnt  <= '0;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

  assign adr       = r_adr;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign dout      = r_dout;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign remaining = r_remaining;

endmodule
